demux_1x8_dist: RTL
===================

DEMUX_1X8_DIST -- requirements
Module: demux_1x8_dist

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per channel.
REQ-002 SHALL have parameter NUM_CH, default 8, meaning number of output channels (fixed at 8; select is 3 bits).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  source presents a beat.
REQ-006 in_data  input  WIDTH  beat payload.
REQ-007 in_sel  input  3  target channel in direct mode; ignored in auto mode.
REQ-008 auto_mode  input  1  1 = internal select counter picks channel, 0 = in_sel picks channel; sampled only in IDLE.
REQ-009 out_clear  input  1  consumer has taken the frame; clears all channels.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 y  output  8*WIDTH  channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 ch_valid  output  8  bit k = channel k written since last clear.
REQ-013 frame_done  output  1  one-cycle pulse when all 8 channels become valid.
REQ-014 cur_sel  output  3  channel the next accepted beat will write.

Function
REQ-015 Beat accepted when in_valid and in_ready are both 1 at a rising edge; no other event writes a channel.
REQ-016 Accepted beat SHALL load in_data into channel cur_sel and set ch_valid[cur_sel] in the same edge; y visible one cycle after acceptance.
REQ-017 Rewriting an already-valid channel in direct mode SHALL overwrite data; ch_valid stays 1.
REQ-018 States: IDLE, FILL, FULL (encoded in the shared package).
REQ-019 IDLE: in_ready = 1; latch auto_mode into a mode register; on accept go to FILL (or FULL if that beat completes the frame).
REQ-020 FILL: in_ready = 1 unless out_clear = 1; go to FULL on the edge where ch_valid becomes 8'hFF.
REQ-021 FULL: in_ready = 0; hold y and ch_valid; leave to IDLE only on out_clear.
REQ-022 frame_done SHALL be 1 for exactly the cycle after the edge on which ch_valid becomes 8'hFF.
REQ-023 Auto mode: cur_sel starts at 0, increments by 1 per accepted beat, never wraps in a frame (after channel 7 the block enters FULL).
REQ-024 Direct mode: cur_sel = in_sel combinationally.
REQ-025 out_clear in any state: next edge sets ch_valid = 0, y = 0, auto counter = 0, state = IDLE.
REQ-026 out_clear and in_valid in the same cycle: in_ready = 0, beat not accepted, clear wins.
REQ-027 in_data and in_sel SHALL be ignored when in_valid = 0.
REQ-028 auto_mode changes outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-029 rst = 1 SHALL immediately force: state IDLE, y = 0, ch_valid = 0, frame_done = 0, auto counter = 0, mode register = 0.
REQ-030 During reset in_ready SHALL read 0; it rises in the first cycle after rst deasserts.
REQ-031 Reset mid-frame SHALL discard the partial frame with no frame_done pulse.

Structure
REQ-032 Shared package demux_pkg SHALL hold the state typedef (IDLE/FILL/FULL), NUM_CH = 8 and SEL_W = 3.
REQ-033 One sub-module demux_ch_reg (WIDTH-bit data register plus valid bit with write-enable and clear) SHALL be instantiated 8 times via generate.
REQ-034 Control FSM, auto counter and handshake logic SHALL live in demux_1x8_dist.

Verification
REQ-035 Auto fill: auto_mode=1, beats 8'h01,02,04,08,10,20,40,80 back-to-back -> y = 64'h8040201008040201, ch_valid = 8'hFF, frame_done single pulse, in_ready = 0 afterwards.
REQ-036 Direct fill out of order: in_sel 7,0,3,1,6,2,5,4 with data = 8'h10 + sel -> each channel k holds 8'h10+k; frame_done after 8th beat only.
REQ-037 Direct overwrite: write ch2 = 8'hAA then ch2 = 8'h55 -> y ch2 = 8'h55, ch_valid = 8'h04, no frame_done.
REQ-038 Back-pressure: in FULL assert in_valid with 8'hFF for 3 cycles -> y unchanged; then out_clear -> next cycle y = 0, ch_valid = 0, in_ready = 1.
REQ-039 Collision: in FILL, out_clear and in_valid together -> beat dropped, ch_valid = 0 next cycle, cur_sel = 0 in auto mode.
REQ-040 Reset mid-frame: after 4 auto beats assert rst asynchronously between edges -> outputs 0 immediately, no frame_done, next frame starts at channel 0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg -- definitions shared by the 1-to-8 distributing demultiplexer.
//   NUM_CH     : number of output channels (fixed at 8)
//   SEL_W      : width of a channel select
//   state_e    : control FSM states (IDLE / FILL / FULL)
//   sel_onehot : decode a channel select into a one-hot channel mask
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// demux_ch_reg -- one output channel: a WIDTH-bit data register plus a
// "written since last clear" flag.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (data and flag to 0)
//   we    : write enable, loads d and sets the flag
//   clr   : synchronous clear of data and flag; takes priority over we
//   d     : write data
//   q     : registered channel data
//   valid : registered written flag
module demux_ch_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (we) begin
      data_q  <= d;
      valid_q <= 1'b1;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux_1x8_dist.sv
// demux_1x8_dist -- distributes a stream of beats into 8 channel registers
// and signals when a full frame (all 8 channels written) is available.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : source presents a beat
//   in_data    : beat payload
//   in_sel     : target channel in direct mode
//   auto_mode  : 1 = internal counter selects channel (sampled in IDLE)
//   out_clear  : consumer has taken the frame; clears every channel
//   in_ready   : a beat is accepted this cycle if in_valid is high
//   y          : channel registers, channel k at [k*WIDTH +: WIDTH]
//   ch_valid   : per-channel written flags
//   frame_done : one-cycle pulse after the frame becomes complete
//   cur_sel    : channel the next accepted beat writes
module demux_1x8_dist
  import demux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    auto_mode,
  input  logic                    out_clear,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] y,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    frame_done,
  output logic [SEL_W-1:0]        cur_sel
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d;

  logic              eff_auto;
  logic              accept;
  logic [NUM_CH-1:0] wr_mask;
  logic              frame_full;

  // In IDLE the mode register has not been loaded yet for this frame, so the
  // live auto_mode input decides; afterwards the latched mode holds.
  assign eff_auto = (state_q == IDLE) ? auto_mode : mode_q;
  assign cur_sel  = eff_auto ? cnt_q : in_sel;

  // Reset is gated in so in_ready reads 0 for the whole reset period and
  // rises as soon as rst drops. A pending clear always blocks the beat.
  assign in_ready   = ~rst & ~out_clear & (state_q != FULL);
  assign accept     = in_valid & in_ready;
  assign wr_mask    = sel_onehot(cur_sel);
  assign frame_full = ((ch_valid | wr_mask) == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d = auto_mode;
        if (accept) begin
          state_d = frame_full ? FULL : FILL;
        end
      end
      FILL: begin
        if (accept && frame_full) begin
          state_d = FULL;
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      fd_d = frame_full;
      // The counter saturates on the last channel; that beat completes the
      // frame, so it is never used again before the next clear.
      if (eff_auto && (cnt_q != SEL_W'(NUM_CH - 1))) begin
        cnt_d = cnt_q + SEL_W'(1);
      end
    end

    if (out_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      fd_d    = 1'b0;
    end
  end

  assign frame_done = fd_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      demux_ch_reg #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && (cur_sel == SEL_W'(gi))),
        .clr  (out_clear),
        .d    (in_data),
        .q    (y[gi*WIDTH +: WIDTH]),
        .valid(ch_valid[gi])
      );
    end
  endgenerate

endmodule
